// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with valid/ready handshake, one-entry skid buffer
// and synchronous flush; in_ready depends on registered state only.
module pipe_skid_reg #(
  parameter int unsigned      WIDTH       = 19,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign occupancy = 2'(state_q);

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= RESET_VALUE;
      skid_q  <= RESET_VALUE;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Flush kills both entries but leaves the data registers untouched.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = FULL;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: a queue of accepted payloads models the stage.
module tb_pipe_skid_reg;

  localparam int unsigned      W  = 19;
  localparam logic [W-1:0]     RV = 19'h12345;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] sb[$];
  bit           rst_flag = 1'b1;

  pipe_skid_reg #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: state checks at +1, handshake checks and pops at +3 after each edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("occupancy", 32'(occupancy), 32'(sb.size()));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      chk("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      if (rst_flag) chk("reset_data", 32'(out_data), 32'(RV));
      #2;
      chk("in_ready_no_comb", 32'(in_ready), 32'(sb.size() < 2));
      if (out_valid && out_ready && reset && !flush) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          chk("out_data", 32'(out_data), 32'(sb.pop_front()));
        end
      end
    end
  end

  // Driver: drives one cycle of inputs and records what the stage must accept.
  task automatic cyc(input logic r, input logic f, input logic v,
                     input logic [W-1:0] d, input logic o);
    int sz;
    @(posedge clk);
    #2;
    reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    sz = sb.size();
    #2;
    if (!r) begin
      sb.delete();
      rst_flag = 1'b1;
    end else if (f) begin
      sb.delete();
    end else if (v && sz < 2) begin
      sb.push_back(d);
      rst_flag = 1'b0;
    end
  endtask

  initial begin
    cyc(1'b0, 1'b0, 1'b1, 19'h7FFFF, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 19'h7FFFF, 1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b1, W'(i), 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    // Skid: A in main, B absorbed while stalled, C held upstream.
    cyc(1'b1, 1'b0, 1'b1, 19'hA, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 19'hB, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 19'hC, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 19'hC, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 19'hC, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    // Flush at full occupancy with a concurrent offer.
    cyc(1'b1, 1'b0, 1'b1, 19'h1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 19'h2, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 19'hD, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    // Reset wins over flush.
    cyc(1'b1, 1'b0, 1'b1, 19'h3, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 19'h4, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 19'h5, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int n = 0; n < 10000; n++) begin
      cyc(1'b0 == 1'b0 ? ($urandom_range(499) != 0) : 1'b1,
          $urandom_range(99) == 0,
          $urandom_range(3) != 0,
          W'($urandom),
          $urandom_range(2) != 0);
    end
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b1);
    @(posedge clk);
    #4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline-stage register with a valid/ready handshake, a one-entry skid buffer, and a synchronous flush. It is the successor to the plain enable/reset stage flip-flop and is used between fetch, decode and the vector issue stages. Back-pressure is absorbed without a combinational ready path, so full throughput is kept while timing paths stay cut at every stage boundary.

## Interface
- WIDTH, 19, payload width in bits (≥1)
- RESET_VALUE, '0, value loaded into both data registers on reset (WIDTH bits)

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-low (0 = reset); sampled on rising edge of clk
- flush  input  1  synchronous kill of all held entries (pipeline redirect)
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept; driven from registered state only
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream accepts
- out_data  output  WIDTH  head payload
- occupancy  output  2  entries held: 0, 1 or 2

## Operation
- Storage: main register (main_data, main_valid) and skid register (skid_data, skid_valid).
- out_valid = main_valid; out_data = main_data (always driven, even when invalid).
- in_ready = !skid_valid; no combinational dependence on out_ready, in_valid or flush.
- occupancy = main_valid + skid_valid.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States (occupancy): EMPTY(0), ONE(1), FULL(2). skid_valid=1 implies main_valid=1.
- EMPTY: in_fire → main←in_data, ONE. Otherwise stay.
- ONE: in_fire & out_fire → main←in_data, stay ONE. in_fire only → skid←in_data, FULL. out_fire only → EMPTY. Neither → hold.
- FULL: in_ready=0, so input is ignored. out_fire → main←skid_data, skid_valid←0, ONE. Otherwise hold.
- Order of precedence per cycle: reset > flush > handshake.
- reset=0: main_valid, skid_valid←0; main_data, skid_data←RESET_VALUE. The whole handshake is ignored in that cycle.
- flush=1 (reset=1): main_valid, skid_valid←0; data registers keep their contents. A concurrent in_fire is dropped and a concurrent out_fire still counts upstream-visible only as the drop; the downstream must treat flush as killing that cycle.
- Data registers load only on the transitions listed; they otherwise hold (no toggling on idle).
- Payload is passed unmodified; there is no arithmetic.

## Timing
- Latency: in_fire at edge N → out_valid=1 with that data from edge N (visible in cycle N+1), i.e. 1 cycle.
- Throughput: 1 transfer/cycle sustained while out_ready=1.
- Back-pressure: after out_ready drops, one more input is absorbed in the skid. in_ready falls one cycle after the stall is seen, never in the same cycle.
- Recovery: from FULL, out_ready=1 gives out_fire that cycle, and in_ready=1 the next cycle.
- Reset values: in_ready=1, out_valid=0, out_data=RESET_VALUE, occupancy=0, all valid from the first edge with reset=0.
- Reset or flush mid-transfer: the state is EMPTY on the following cycle regardless of prior occupancy or handshake inputs.
- Ordering: entries leave in acceptance order. No duplication or loss except through flush or reset.

## Test plan
- Reset: hold reset=0 for 2 cycles with in_valid=1, in_data=0x7FFFF, RESET_VALUE=0x12345 → out_valid=0, out_data=0x12345, in_ready=1, occupancy=0.
- Streaming: out_ready=1, push 0x1..0x8 on consecutive cycles → outputs 0x1..0x8 on consecutive cycles with 1-cycle latency and in_ready constantly 1.
- Skid: with main holding 0xA, drop out_ready while 0xB is offered → 0xB accepted, occupancy=2, in_ready=0 next cycle, 0xC held upstream. Raise out_ready → 0xA, 0xB, 0xC emerge in order with no gap after the first.
- Flush: at occupancy=2 with in_valid=1 (0xD) and flush=1 → next cycle occupancy=0, out_valid=0, in_ready=1; 0xD never appears at the output.
- Reset over flush: reset=0 and flush=1 together at occupancy=2 → occupancy=0, out_data=RESET_VALUE.
- Random: random in_valid/out_ready/data for 10k cycles with a scoreboard → output sequence equals accepted sequence, and in_ready has no combinational dependency on out_ready.
